// File: rtl/noc_pkg.sv
// Shared definitions for the NoC network-interface injector: flit layout,
// type encodings, VC count and the injector FSM state set.
package noc_pkg;

   localparam int unsigned FLIT_W    = 68;
   localparam int unsigned PAYLOAD_W = 64;
   localparam int unsigned NUM_VC    = 2;
   localparam int unsigned NODE_W    = 4;
   localparam int unsigned LEN_W     = 5;

   localparam int unsigned F_VALID   = 0;
   localparam int unsigned F_VC      = 1;
   localparam int unsigned F_TYPE    = 2;
   localparam int unsigned F_PAYLOAD = 4;

   // Head-flit fields, as offsets inside the 64-bit payload
   localparam int unsigned HD_DEST = 0;
   localparam int unsigned HD_SRC  = 4;
   localparam int unsigned HD_LEN  = 8;

   typedef enum logic [1:0] {
      FLIT_BODY   = 2'b00,
      FLIT_HEAD   = 2'b01,
      FLIT_TAIL   = 2'b10,
      FLIT_SINGLE = 2'b11
   } flit_type_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HEAD,
      ST_BODY
   } ni_state_e;

   function automatic logic [FLIT_W-1:0] make_flit(input logic vc,
                                                   input flit_type_e t,
                                                   input logic [PAYLOAD_W-1:0] payload);
      logic [FLIT_W-1:0] f;
      f                          = '0;
      f[F_VALID]                 = 1'b1;
      f[F_VC]                    = vc;
      f[F_TYPE +: 2]             = t;
      f[F_PAYLOAD +: PAYLOAD_W]  = payload;
      return f;
   endfunction

   function automatic logic [PAYLOAD_W-1:0] head_payload(input logic [NODE_W-1:0] dest,
                                                        input logic [NODE_W-1:0] src,
                                                        input logic [LEN_W-1:0]  len);
      logic [PAYLOAD_W-1:0] p;
      p                    = '0;
      p[HD_DEST +: NODE_W] = dest;
      p[HD_SRC  +: NODE_W] = src;
      p[HD_LEN  +: LEN_W]  = len;
      return p;
   endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Per-VC credit counter: starts full, saturates at DEPTH, flags a return that
// arrives while already full (count left unchanged).
module noc_credit_counter #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic [CNT_W-1:0] count_nxt,
   output logic             avail,
   output logic             overflow
);

   always_comb begin
      count_nxt = count;
      overflow  = 1'b0;
      if (inc && !dec) begin
         if (count == CNT_W'(DEPTH)) overflow  = 1'b1;
         else                        count_nxt = count + CNT_W'(1);
      end else if (dec && !inc && count != '0) begin
         count_nxt = count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) count <= CNT_W'(DEPTH);
      else       count <= count_nxt;
   end

   assign avail = (count != '0);

endmodule

// File: rtl/noc_ni_tx.sv
// NoC injector: turns host packets into 68-bit flits with 2-VC credit flow control.
// Optional NI_TX_ERR_CHK_EN: credit return into a full counter also sets error.
module noc_ni_tx
   import noc_pkg::*;
#(
   parameter int unsigned BUF_DEPTH = 4,
   parameter int unsigned MAX_LEN   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NODE_W-1:0]  router_address,
   input  logic               pkt_valid,
   output logic               pkt_ready,
   input  logic [NODE_W-1:0]  pkt_dest,
   input  logic [LEN_W-1:0]   pkt_len,
   input  logic               word_valid,
   output logic               word_ready,
   input  logic [PAYLOAD_W-1:0] word_data,
   input  logic [NUM_VC-1:0]  flow_ctrl_in,
   output logic [FLIT_W-1:0]  channel_out,
   output logic               error
);

   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

`ifdef NI_TX_ERR_CHK_EN
   localparam bit OVF_IS_ERR = 1'b1;
`else
   localparam bit OVF_IS_ERR = 1'b0;
`endif

   ni_state_e          state;
   logic               vc;
   logic [NODE_W-1:0]  dest_q;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   remaining;
   logic               bad_len_q;

   logic [NUM_VC-1:0]  cr_inc, cr_dec, cr_avail, cr_ovf;
   logic [CNT_W-1:0]   cr_count     [NUM_VC];
   logic [CNT_W-1:0]   cr_count_nxt [NUM_VC];

   logic pkt_fire, word_fire, head_fire, bad_len_in, pick_vc, any_avail_nxt, err_event;

   for (genvar g = 0; g < NUM_VC; g++) begin : g_credit
      noc_credit_counter #(
         .DEPTH (BUF_DEPTH),
         .CNT_W (CNT_W)
      ) u_credit (
         .clk       (clk),
         .reset     (reset),
         .inc       (cr_inc[g]),
         .dec       (cr_dec[g]),
         .count     (cr_count[g]),
         .count_nxt (cr_count_nxt[g]),
         .avail     (cr_avail[g]),
         .overflow  (cr_ovf[g])
      );
   end

   assign pkt_fire      = pkt_valid & pkt_ready;
   assign word_fire     = word_valid & word_ready;
   assign head_fire     = (state == ST_HEAD) & cr_avail[vc];
   assign bad_len_in    = (pkt_len == '0) || (32'(pkt_len) > MAX_LEN);
   assign pick_vc       = (cr_count[1] > cr_count[0]);
   assign any_avail_nxt = (cr_count_nxt[0] != '0) || (cr_count_nxt[1] != '0);
   assign err_event     = (pkt_fire & bad_len_in) | (OVF_IS_ERR & (|cr_ovf));
   assign cr_inc        = flow_ctrl_in;

   always_comb begin
      cr_dec = '0;
      if (head_fire || word_fire) cr_dec[vc] = 1'b1;
   end

   // Ready flags are registered from the counters' next values, so they match
   // what a combinational ready would show in the following cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         vc          <= 1'b0;
         dest_q      <= '0;
         len_q       <= '0;
         remaining   <= '0;
         bad_len_q   <= 1'b0;
         pkt_ready   <= 1'b0;
         word_ready  <= 1'b0;
         channel_out <= '0;
         error       <= 1'b0;
      end else begin
         channel_out <= '0;
         if (err_event) error <= 1'b1;
         case (state)
            ST_IDLE: begin
               pkt_ready <= any_avail_nxt;
               if (pkt_fire) begin
                  state     <= ST_HEAD;
                  pkt_ready <= 1'b0;
                  vc        <= pick_vc;
                  dest_q    <= pkt_dest;
                  len_q     <= pkt_len;
                  remaining <= pkt_len;
                  bad_len_q <= bad_len_in;
               end
            end
            ST_HEAD: begin
               if (head_fire) begin
                  channel_out <= make_flit(vc, bad_len_q ? FLIT_SINGLE : FLIT_HEAD,
                                           head_payload(dest_q, router_address, len_q));
                  if (bad_len_q) begin
                     state     <= ST_IDLE;
                     pkt_ready <= any_avail_nxt;
                  end else begin
                     state      <= ST_BODY;
                     word_ready <= (cr_count_nxt[vc] != '0);
                  end
               end
            end
            ST_BODY: begin
               word_ready <= (cr_count_nxt[vc] != '0);
               if (word_fire) begin
                  channel_out <= make_flit(vc, (remaining == 5'd1) ? FLIT_TAIL : FLIT_BODY,
                                           word_data);
                  remaining   <= remaining - 5'd1;
                  if (remaining == 5'd1) begin
                     state      <= ST_IDLE;
                     word_ready <= 1'b0;
                     pkt_ready  <= any_avail_nxt;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_noc_ni_tx.sv
// Scoreboard bench for noc_ni_tx: a credit-level model predicts every flit,
// a monitor compares emitted flits and emulates the router's credit returns.
module tb_noc_ni_tx;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  router_address;
   logic        pkt_valid;
   logic        pkt_ready;
   logic [3:0]  pkt_dest;
   logic [4:0]  pkt_len;
   logic        word_valid;
   logic        word_ready;
   logic [63:0] word_data;
   logic [1:0]  flow_ctrl_in = '0;
   logic [67:0] channel_out;
   logic        error;

   always #5 clk = ~clk;

   noc_ni_tx #(.BUF_DEPTH(DEPTH), .MAX_LEN(16)) dut (
      .clk            (clk),
      .reset          (reset),
      .router_address (router_address),
      .pkt_valid      (pkt_valid),
      .pkt_ready      (pkt_ready),
      .pkt_dest       (pkt_dest),
      .pkt_len        (pkt_len),
      .word_valid     (word_valid),
      .word_ready     (word_ready),
      .word_data      (word_data),
      .flow_ctrl_in   (flow_ctrl_in),
      .channel_out    (channel_out),
      .error          (error)
   );

   typedef struct {
      int vc;
      int due;
   } ret_t;

   int          n_cmp = 0, n_bad = 0;
   logic [67:0] exp_q[$];
   ret_t        pend[$];
   int          cyc = 0, flits_seen = 0, last_flit_cyc = 0, rel_cyc = 0;
   int          sent[2] = '{0, 0}, returned[2] = '{0, 0};
   int          rel_req[2] = '{0, 0}, rel_done[2] = '{0, 0};
   int          spur_req = 0, spur_done = 0;
   bit          ret_en = 1'b0;
   bit          err_exp = 1'b0;
   int          cur_vc = 0, words_left = 0;

   task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [67:0] fl(input int vc, input logic [1:0] typ, input logic [63:0] pl);
      logic [67:0] f;
      f       = '0;
      f[0]    = 1'b1;
      f[1]    = vc[0];
      f[3:2]  = typ;
      f[67:4] = pl;
      return f;
   endfunction

   // Model: credits = depth - flits issued + credits returned; choose the richer VC.
   initial begin
      int c[2];
      logic [63:0] hp;
      forever begin
         @(negedge clk);
         #4;
         if (reset) begin
            exp_q.delete();
            sent = '{0, 0};
            returned = '{0, 0};
            words_left = 0;
            err_exp = 1'b0;
         end else begin
            if (pkt_valid && pkt_ready) begin
               for (int v = 0; v < 2; v++) c[v] = DEPTH - sent[v] + returned[v];
               cur_vc = (c[1] > c[0]) ? 1 : 0;
               hp = '0;
               hp[3:0]  = pkt_dest;
               hp[7:4]  = router_address;
               hp[12:8] = pkt_len;
               if (pkt_len == 0 || pkt_len > 16) begin
                  exp_q.push_back(fl(cur_vc, 2'b11, hp));
                  err_exp = 1'b1;
                  words_left = 0;
               end else begin
                  exp_q.push_back(fl(cur_vc, 2'b01, hp));
                  words_left = int'(pkt_len);
               end
               sent[cur_vc]++;
            end
            if (word_valid && word_ready) begin
               if (words_left == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL word_outside_packet: got word_ready=1 expected 0");
               end else begin
                  exp_q.push_back(fl(cur_vc, (words_left == 1) ? 2'b10 : 2'b00, word_data));
                  words_left--;
                  sent[cur_vc]++;
               end
            end
            for (int v = 0; v < 2; v++) begin
               if (flow_ctrl_in[v]) begin
                  if (DEPTH - sent[v] + returned[v] < DEPTH) returned[v]++;
                  else begin
`ifdef NI_TX_ERR_CHK_EN
                     err_exp = 1'b1;
`endif
                  end
               end
            end
         end
      end
   end

   // Monitor and router emulation: compare flits, return one credit per received flit.
   initial begin
      logic [1:0] fc;
      ret_t r;
      int i;
      forever begin
         @(negedge clk);
         cyc++;
         if (channel_out[0]) begin
            flits_seen++;
            last_flit_cyc = cyc;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_flit: got %h expected none", channel_out);
            end else begin
               check("flit", channel_out, exp_q.pop_front());
            end
            r.vc  = int'(channel_out[1]);
            r.due = cyc + int'($urandom_range(0, 6));
            pend.push_back(r);
         end else begin
            check("bubble", channel_out, '0);
         end
         fc = '0;
         if (reset) begin
            pend.delete();
         end else begin
            for (int v = 0; v < 2; v++) begin
               if (rel_done[v] < rel_req[v]) begin
                  for (int k = 0; k < pend.size(); k++) begin
                     if (pend[k].vc == v) begin
                        pend.delete(k);
                        fc[v] = 1'b1;
                        rel_done[v]++;
                        rel_cyc = cyc;
                        break;
                     end
                  end
               end
            end
            if (spur_done < spur_req) begin
               fc = 2'b11;
               spur_done++;
            end
            if (ret_en) begin
               i = 0;
               while (i < pend.size()) begin
                  if (fc[pend[i].vc] == 1'b0 && pend[i].due <= cyc) begin
                     fc[pend[i].vc] = 1'b1;
                     pend.delete(i);
                  end else begin
                     i++;
                  end
               end
            end
         end
         flow_ctrl_in = fc;
      end
   end

   task automatic send_pkt(input logic [3:0] d, input logic [4:0] l);
      int t = 0;
      pkt_dest  = d;
      pkt_len   = l;
      pkt_valid = 1'b1;
      while (!pkt_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("pkt_accept_wait", pkt_ready, 1);
      @(negedge clk);
      pkt_valid = 1'b0;
   endtask

   task automatic send_word(input logic [63:0] d, input int gap);
      int t = 0;
      word_valid = 1'b0;
      repeat (gap) @(negedge clk);
      word_data  = d;
      word_valid = 1'b1;
      while (!word_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      check("word_accept_wait", word_ready, 1);
      @(negedge clk);
      word_valid = 1'b0;
   endtask

   task automatic wait_flits(input int n, input int budget);
      int t = 0;
      while (flits_seen < n && t < budget) begin
         @(negedge clk);
         t++;
      end
      check("flit_count_wait", flits_seen >= n, 1);
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("scoreboard_drained", exp_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int base;
      reset = 1'b1;
      router_address = 4'd2;
      pkt_valid = 1'b0;
      pkt_dest = '0;
      pkt_len = '0;
      word_valid = 1'b0;
      word_data = '0;
      repeat (3) @(negedge clk);
      check("rst_channel_out", channel_out, '0);
      check("rst_pkt_ready", pkt_ready, 0);
      check("rst_word_ready", word_ready, 0);
      check("rst_error", error, 0);
      reset = 1'b0;
      @(negedge clk);

      // Credit returns into full counters
      spur_req = 1;
      repeat (4) @(negedge clk);
      check("error_after_full_return", error, err_exp);

      // dest 5 len 3 from node 2, then a 6-word packet that runs out of credits
      send_pkt(4'd5, 5'd3);
      send_word(64'hAAAA_0000_0000_000A, 0);
      send_word(64'hBBBB_0000_0000_000B, 0);
      send_word(64'hCCCC_0000_0000_000C, 0);
      wait_flits(4, 50);
      fork
         begin
            send_pkt(4'd9, 5'd6);
            for (int w = 0; w < 6; w++) send_word({$urandom, $urandom}, 0);
         end
         begin
            wait_flits(8, 100);
            repeat (10) @(negedge clk);
            check("stall_flit_count", flits_seen, 8);
            check("stall_word_ready", word_ready, 0);
            rel_req[1]++;
            wait_flits(9, 20);
            check("credit_return_latency", last_flit_cyc - rel_cyc, 2);
            ret_en = 1'b1;
         end
      join
      drain();

      // Random traffic with back-to-back packets and word gaps
      for (int p = 0; p < 30; p++) begin
         int len;
         len = int'($urandom_range(1, 16));
         send_pkt(4'($urandom_range(0, 15)), 5'(len));
         for (int w = 0; w < len; w++) send_word({$urandom, $urandom}, int'($urandom_range(0, 2)));
      end
      drain();
      repeat (12) @(negedge clk);

      // Reset right after a head flit
      ret_en = 1'b0;
      base = flits_seen;
      send_pkt(4'd3, 5'd8);
      wait_flits(base + 1, 20);
      reset = 1'b1;
      @(negedge clk);
      check("reset_mid_channel", channel_out, '0);
      check("reset_mid_pkt_ready", pkt_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("post_reset_pkt_ready", pkt_ready, 1);
      check("post_reset_error", error, err_exp);
      send_pkt(4'd1, 5'd2);
      send_word(64'h1111, 0);
      send_word(64'h2222, 0);
      send_pkt(4'd2, 5'd2);
      send_word(64'h3333, 0);
      send_word(64'h4444, 0);
      drain();

      // Illegal lengths, then the shortest legal packet
      ret_en = 1'b1;
      send_pkt(4'd7, 5'd0);
      send_pkt(4'd6, 5'd20);
      send_pkt(4'd4, 5'd1);
      send_word(64'hDEAD_BEEF_0123_4567, 0);
      drain();
      check("error_after_bad_len", error, err_exp);
      check("error_model_set", err_exp, 1);

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
